uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 14 +
 rtl/tx_fifo.sv | 54 +++++
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and FSM state type.
package uart_pkg;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Power-of-two ring-buffer FIFO with registered occupancy and a fall-through head word.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; the pointers and count alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small FIFO, with synchronized CTS flow control.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DIV   = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             din,
  input  logic                   din_valid,
  output logic                   din_ready,
  input  logic                   cts_n,
  output logic                   txd,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int          BW        = $clog2(DATA_BITS);
  localparam logic [15:0] BAUD_LOAD = 16'(DIV - 1);

  tx_state_t              state;
  logic [DATA_BITS-1:0]   shift;
  logic [BW-1:0]          bit_cnt;
  logic [15:0]            baud_cnt;
  logic                   txd_q;
  logic                   txd_next;
  logic                   cts_meta;
  logic                   cts_s;
  logic                   ready_en;
  logic [7:0]             fifo_head;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   start_ok;
  logic                   baud_done;

  tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // ready_en holds din_ready low through reset and releases it on the first edge afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta <= 1'b1;
      cts_s    <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      cts_meta <= cts_n;
      cts_s    <= cts_meta;
      ready_en <= 1'b1;
    end
  end

  assign din_ready = ready_en && !fifo_full;
  assign push      = din_valid && din_ready;
  assign start_ok  = !fifo_empty && !cts_s;
  assign baud_done = (baud_cnt == '0);
  assign pop       = start_ok && ((state == IDLE) || ((state == STOP) && baud_done));
  assign busy      = (state != IDLE) || !fifo_empty;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift    <= fifo_head;
            bit_cnt  <= '0;
            baud_cnt <= BAUD_LOAD;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= BAUD_LOAD;
            shift    <= shift >> 1;
            if (bit_cnt == BW'(DATA_BITS - 1)) state <= STOP;
            else                               bit_cnt <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        STOP: begin
          // Chaining straight into START keeps back-to-back frames gap-free.
          if (baud_done) begin
            if (pop) begin
              shift    <= fifo_head;
              bit_cnt  <= '0;
              baud_cnt <= BAUD_LOAD;
              state    <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: txd_next is defaulted before the case so the decode cannot infer a latch.
  always_comb begin
    txd_next = 1'b1;
    case (state)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift[0];
      default: txd_next = 1'b1;
    endcase
  end

  // Registered line driver: glitch-free, and reset forces the line high immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) txd_q <= 1'b1;
    else       txd_q <= txd_next;
  end

  assign txd = txd_q;

endmodule
